// File: rtl/cache_ctrl.sv
// cache_ctrl: blocking write-back controller that sits between the pipeline
// memory stage, a direct-mapped cache with 4-word lines, and a memory with a
// fixed 2-cycle read latency. A miss evicts a dirty victim (WB0-WB3), refills
// the line (AL0-AL5), and then replays the request as a compare access (FINAL).
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        c_en,
  output logic [15:0] c_addr,
  output logic        c_comp,
  output logic        c_write,
  output logic [15:0] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out
);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, WB2, WB3, AL0, AL1, AL2, AL3, AL4, AL5, FINAL
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_wr;
  logic        w_req;
  logic        w_hit;
  logic [4:0]  w_tag;
  logic [7:0]  w_idx;
  logic [1:0]  w_word;
  logic [1:0]  w_fill_word;

  assign w_req = Rd | Wr;
  assign w_hit = c_hit & c_valid;
  assign w_tag = r_addr[15:11];
  assign w_idx = r_addr[10:3];

  // State register and request latch (captured only when a request starts)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_addr <= Addr;
        r_data <= DataIn;
        r_wr   <= Wr;
      end
    end
  end

  // Next-state: miss sequencing through optional write-back then allocate
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req && !w_hit) w_next = (c_valid && c_dirty) ? WB0 : AL0;
      WB0:     w_next = WB1;
      WB1:     w_next = WB2;
      WB2:     w_next = WB3;
      WB3:     w_next = AL0;
      AL0:     w_next = AL1;
      AL1:     w_next = AL2;
      AL2:     w_next = AL3;
      AL3:     w_next = AL4;
      AL4:     w_next = AL5;
      AL5:     w_next = FINAL;
      FINAL:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Word offsets: victim/memory-read word k, fill word trails reads by two
  // cycles to match the memory latency
  always_comb begin
    w_word      = 2'd0;
    w_fill_word = 2'd0;
    case (r_state)
      WB1, AL1: w_word = 2'd1;
      WB2:      w_word = 2'd2;
      WB3:      w_word = 2'd3;
      AL2:      w_word = 2'd2;
      AL3: begin
        w_word      = 2'd3;
        w_fill_word = 2'd1;
      end
      AL4:      w_fill_word = 2'd2;
      AL5:      w_fill_word = 2'd3;
      default: begin
        w_word      = 2'd0;
        w_fill_word = 2'd0;
      end
    endcase
  end

  // Outputs: decoded from state (plus live request in IDLE), forced low in reset
  always_comb begin
    DataOut   = '0;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    c_en      = 1'b0;
    c_addr    = '0;
    c_comp    = 1'b0;
    c_write   = 1'b0;
    c_data_in = '0;
    m_addr    = '0;
    m_data_in = '0;
    m_wr      = 1'b0;
    m_rd      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          c_en      = 1'b1;
          c_comp    = 1'b1;
          c_write   = Wr;
          c_addr    = Addr;
          c_data_in = DataIn;
          if (w_hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            DataOut  = c_data_out;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      WB0, WB1, WB2, WB3: begin
        Stall     = 1'b1;
        c_en      = 1'b1;
        c_addr    = {w_tag, w_idx, w_word, 1'b0};
        m_wr      = 1'b1;
        m_addr    = {c_tag_out, w_idx, w_word, 1'b0};
        m_data_in = c_data_out;
      end
      AL0, AL1, AL2, AL3, AL4, AL5: begin
        Stall = 1'b1;
        if (r_state == AL0 || r_state == AL1 || r_state == AL2 || r_state == AL3) begin
          m_rd   = 1'b1;
          m_addr = {w_tag, w_idx, w_word, 1'b0};
        end
        if (r_state == AL2 || r_state == AL3 || r_state == AL4 || r_state == AL5) begin
          c_en      = 1'b1;
          c_write   = 1'b1;
          c_addr    = {w_tag, w_idx, w_fill_word, 1'b0};
          c_data_in = m_data_out;
        end
      end
      FINAL: begin
        c_en      = 1'b1;
        c_comp    = 1'b1;
        c_write   = r_wr;
        c_addr    = r_addr;
        c_data_in = r_data;
        Done      = 1'b1;
        DataOut   = c_data_out;
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
    if (rst) begin
      DataOut   = '0;
      Done      = 1'b0;
      Stall     = 1'b0;
      CacheHit  = 1'b0;
      c_en      = 1'b0;
      c_addr    = '0;
      c_comp    = 1'b0;
      c_write   = 1'b0;
      c_data_in = '0;
      m_addr    = '0;
      m_data_in = '0;
      m_wr      = 1'b0;
      m_rd      = 1'b0;
    end
  end

endmodule
